// File: rtl/pipe_pkg.sv
// Shared opcode/funct/fmt constants and FSM state type for the IF/ID hazard controller.
package pipe_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned FMT_W      = 5;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned STALL_CNT_W = 16;

  localparam logic [OP_W-1:0]  OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0]  OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0]  OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0]  OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0]  OP_COP1  = 6'h11;
  localparam logic [FMT_W-1:0] FMT_S    = 5'h10;
  localparam logic [OP_W-1:0]  FN_MULS  = 6'h02;
  localparam logic [OP_W-1:0]  FN_DIVS  = 6'h03;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  // Instructions whose rt field is a source operand.
  function automatic logic uses_rt(input logic [OP_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Combinational load-use hazard detection between the load in EX and the instruction in ID.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             i_mem_read_ex,
  input  logic [REG_W-1:0] i_rt_ex,
  input  logic [REG_W-1:0] i_rs_id,
  input  logic [REG_W-1:0] i_rt_id,
  input  logic [OP_W-1:0]  i_op_code,
  output logic             o_load_hz
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = (i_rt_ex == i_rs_id);
  assign w_rt_match = uses_rt(i_op_code) && (i_rt_ex == i_rt_id);
  // A load to $zero produces nothing to wait for.
  assign o_load_hz  = i_mem_read_ex && (i_rt_ex != '0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// IF/ID and PC sequencing: load-use stalls, branch/jump flushes, multi-cycle COP1
// mul/div occupancy, plus a saturating stalled-cycle counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FP_MUL_LAT = 4,
  parameter int unsigned FP_DIV_LAT = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [5:0]             Op_code,
  input  logic [5:0]             Funct_ID,
  input  logic [4:0]             Fmt,
  input  logic [4:0]             Rs_ID,
  input  logic [4:0]             Rt_ID,
  input  logic                   MemRead_EX,
  input  logic [4:0]             Rt_EX,
  input  logic                   Branch_taken,
  input  logic                   Jump,
  output logic                   IF_stall,
  output logic                   IF_Flush,
  output logic                   PC_write,
  output logic                   ID_bubble,
  output logic                   FP_busy,
  output logic [15:0]            Stall_cnt
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_mc_cnt;
  logic [CNT_W-1:0]       w_mc_cnt_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_load_hz;
  logic                   w_fp_mc;

  load_use_detect u_load_use_detect (
    .i_mem_read_ex (MemRead_EX),
    .i_rt_ex       (Rt_EX),
    .i_rs_id       (Rs_ID),
    .i_rt_id       (Rt_ID),
    .i_op_code     (Op_code),
    .o_load_hz     (w_load_hz)
  );

  assign w_fp_mc   = (Op_code == OP_COP1) && (Fmt == FMT_S) &&
                     ((Funct_ID == FN_MULS) || (Funct_ID == FN_DIVS));
  assign Stall_cnt = r_stall_cnt;

  // State, occupancy counter and saturating stall counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= RUN;
      r_mc_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
      if (IF_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  // Next state and Mealy outputs; reset forces a flush-and-bubble pattern.
  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    IF_stall     = 1'b0;
    IF_Flush     = 1'b0;
    PC_write     = 1'b1;
    ID_bubble    = 1'b0;
    FP_busy      = 1'b0;
    if (!Rst_n) begin
      IF_Flush     = 1'b1;
      PC_write     = 1'b0;
      ID_bubble    = 1'b1;
      w_state_nxt  = RUN;
      w_mc_cnt_nxt = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_load_hz) begin
            IF_stall  = 1'b1;
            PC_write  = 1'b0;
            ID_bubble = 1'b1;
          end else if (w_fp_mc) begin
            // Issue cycle itself looks idle; occupancy starts at the next edge.
            w_state_nxt  = MC_WAIT;
            w_mc_cnt_nxt = (Funct_ID == FN_DIVS) ? CNT_W'(FP_DIV_LAT - 2)
                                                 : CNT_W'(FP_MUL_LAT - 2);
          end else if (Branch_taken || Jump) begin
            IF_Flush = 1'b1;
          end
        end
        MC_WAIT: begin
          IF_stall  = 1'b1;
          PC_write  = 1'b0;
          ID_bubble = 1'b1;
          FP_busy   = 1'b1;
          if (r_mc_cnt == '0) begin
            w_state_nxt = RUN;
          end else begin
            w_mc_cnt_nxt = r_mc_cnt - CNT_W'(1);
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Sequencing controller for the IF/ID pipeline register and PC. It decodes the instruction currently held in ID and generates IF_stall, IF_Flush, PC_write and ID_bubble. These signals handle load-use hazards, taken branches and jumps, and multi-cycle COP1 multiply/divide occupancy. It sits beside IF_ID, drives that register's stall/flush inputs, and keeps a saturating stall-cycle performance counter.

## Interface
- FP_MUL_LAT, 4: total EX cycles of COP1 mul.s (≥2)
- FP_DIV_LAT, 8: total EX cycles of COP1 div.s (≥2)
- CNT_W, 4: width of occupancy down-counter (must hold max(LAT)-1)
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- Op_code  in  6  opcode of ID instruction
- Funct_ID  in  6  funct field of ID instruction
- Fmt  in  5  COP1 format field of ID instruction
- Rs_ID  in  5  rs of ID instruction
- Rt_ID  in  5  rt of ID instruction
- MemRead_EX  in  1  instruction in EX is a load
- Rt_EX  in  5  load destination in EX
- Branch_taken  in  1  branch in ID resolved taken
- Jump  in  1  j/jal in ID
- IF_stall  out  1  hold IF/ID contents
- IF_Flush  out  1  zero IF/ID contents at next edge
- PC_write  out  1  PC may update
- ID_bubble  out  1  inject zero control into ID/EX
- FP_busy  out  1  multi-cycle COP1 op occupying EX
- Stall_cnt  out  16  saturating count of stalled cycles

## Operation
- States: RUN, MC_WAIT. Register mc_cnt[CNT_W-1:0].
- uses_rt = (Op_code==6'h00)|(6'h04 beq)|(6'h05 bne)|(6'h2B sw).
- load_hz = MemRead_EX & (Rt_EX!=0) & ((Rt_EX==Rs_ID) | (uses_rt & Rt_EX==Rt_ID)).
- fp_mc = (Op_code==6'h11) & (Fmt==5'h10) & (Funct_ID==6'h02 mul | 6'h03 div).
- Priority in RUN: load_hz > fp_mc issue > Branch_taken|Jump flush.
- RUN, load_hz: IF_stall=1, PC_write=0, ID_bubble=1, IF_Flush=0. The branch/jump flush is suppressed and re-evaluated next cycle.
- RUN, fp_mc, no load_hz: the op issues normally (outputs as idle). Next edge: state→MC_WAIT, mc_cnt←LAT-2 (mul or div per funct).
- RUN, Branch_taken|Jump, no load_hz: IF_Flush=1 for one cycle, PC_write=1, IF_stall=0.
- RUN, idle: IF_stall=0, IF_Flush=0, PC_write=1, ID_bubble=0.
- MC_WAIT: IF_stall=1, PC_write=0, ID_bubble=1, IF_Flush=0, FP_busy=1. All ID inputs are ignored. mc_cnt decrements each edge. When mc_cnt==0 at an edge → RUN.
- Stall_cnt increments on every edge where IF_stall=1. It saturates at 16'hFFFF and never wraps.

## Timing
- Outputs are combinational (Mealy) from state and current ID/EX inputs. They take effect at the same edge as the hazard.
- Load-use: exactly 1 stall cycle, provided the injected bubble clears MemRead_EX.
- COP1 mul/div: the issue cycle is followed by exactly LAT-1 stall cycles (mul 3, div 7 at defaults). RUN is re-entered on the edge after mc_cnt reaches 0.
- Flush: 1-cycle IF_Flush pulse. A branch held under load_hz flushes in the first unstalled cycle.
- Rst_n low, asynchronous: state=RUN, mc_cnt=0, Stall_cnt=0, FP_busy=0, IF_stall=0, IF_Flush=1, PC_write=0, ID_bubble=1.
- Rst_n rising: behaviour follows RUN from the first edge. Reset mid-MC_WAIT aborts the occupancy with no residual stall.
- Rt_EX==0 never stalls. In MC_WAIT, simultaneous load_hz, fp_mc or branch have no effect.

## Structure
- Package pipe_pkg: opcode/funct/fmt constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_COP1, FMT_S, FN_MULS, FN_DIVS) and the state enum {RUN, MC_WAIT}.
- Sub-module load_use_detect (combinational): produces load_hz. The FSM, counter and performance counter stay in the top.

## Test plan
- Reset asserted mid-stream → IF_Flush=1, PC_write=0, Stall_cnt=0. After release, with no hazard → IF_stall=0, PC_write=1.
- MemRead_EX=1, Rt_EX=8, Op_code=0, Rt_ID=8 → exactly 1 cycle IF_stall=1/ID_bubble=1, and Stall_cnt=1. Repeating with Rt_EX=0 → no stall.
- Op_code=6'h11, Fmt=5'h10, Funct=6'h03 → FP_busy/IF_stall high for 7 consecutive cycles, then RUN. With Funct=6'h02 → 3 cycles.
- Load-use and Branch_taken together → 1 stall cycle with IF_Flush=0, then IF_Flush=1 for 1 cycle.
- Rst_n pulsed low in the 3rd cycle of div MC_WAIT → FP_busy drops immediately, and no stall follows release.
- Force 65,540 stall cycles → Stall_cnt holds 16'hFFFF.
